pe_input_feeder: RTL and testbench

- Transmitter side of the PE input buffers: fetches one filter and a block of IFMap rows from a synchronous-read memory and pushes them into the PE's Filter and IFMap FIFO buffers.
- Drives the buffers' write-enable/data pins and honours their full flags.
- Tags each IFMap word with start-of-row/end-of-row flags in the two MSBs, as the PE IFMap controller expects.
- Sits between the global memory/loader and one PE datapath instance.

---
 rtl/pe_input_feeder.sv | 182 ++++++++++++++++++
 tb/tb_pe_input_feeder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_input_feeder.sv
// Streams one filter and a block of IFMap rows from a synchronous-read memory
// into the PE Filter/IFMap FIFO buffers, tagging IFMap words with row flags.
module pe_input_feeder #(
  parameter int IFMAP_WIDTH  = 18,
  parameter int FILTER_WIDTH = 8,
  parameter int ADDR_WIDTH   = 12,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  ifmap_base,
  input  logic [ADDR_WIDTH-1:0]  filter_base,
  input  logic [LEN_WIDTH-1:0]   row_len,
  input  logic [LEN_WIDTH-1:0]   num_rows,
  input  logic [LEN_WIDTH-1:0]   filter_size,
  output logic                   mem_ren,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [IFMAP_WIDTH-3:0] mem_rdata,
  output logic [IFMAP_WIDTH-1:0] IFMap_in,
  output logic                   wen_IFMap_buffer,
  input  logic                   IFMap_full,
  output logic [FILTER_WIDTH-1:0] Filter_in,
  output logic                   wen_Filter_buffer,
  input  logic                   Filter_full,
  output logic                   busy,
  output logic                   done
);
  localparam int DW = IFMAP_WIDTH - 2;

  typedef enum logic [1:0] {S_IDLE, S_FILT, S_IFMAP, S_DRAIN} state_t;

  typedef struct packed {
    logic tgt_ifm;
    logic sr;
    logic er;
  } tag_t;

  typedef struct packed {
    logic [DW-1:0] data;
    tag_t          tag;
  } skid_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] f_addr, i_addr;
  logic [LEN_WIDTH-1:0]  fs_q, rl_q, nr_q;
  logic [LEN_WIDTH-1:0]  f_cnt, col, row;

  logic  rd_inflight;
  tag_t  rd_tag, rd_tag_q;

  skid_t      skid_mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] cnt;
  skid_t      head;

  logic       wr_ifm, wr_flt, pop;
  logic [2:0] occ;
  logic       can_issue;
  logic       f_last, i_last, drained, ifm_nonzero;

  // Head of the skid goes straight to its buffer whenever that buffer has room.
  assign head    = skid_mem[rd_ptr];
  assign wr_ifm  = (cnt != 2'd0) &&  head.tag.tgt_ifm && !IFMap_full;
  assign wr_flt  = (cnt != 2'd0) && !head.tag.tgt_ifm && !Filter_full;
  assign pop     = wr_ifm || wr_flt;

  assign wen_IFMap_buffer  = wr_ifm;
  assign wen_Filter_buffer = wr_flt;
  assign IFMap_in  = wr_ifm ? {head.tag.sr, head.tag.er, head.data} : '0;
  assign Filter_in = wr_flt ? head.data[FILTER_WIDTH-1:0] : '0;

  // A read may only be issued if its data is guaranteed a skid slot on return.
  assign occ       = {1'b0, cnt} + {2'b0, rd_inflight};
  assign can_issue = occ < (3'd2 + {2'b0, pop});

  assign f_last      = (f_cnt == fs_q - 1'b1);
  assign i_last      = (col == rl_q - 1'b1) && (row == nr_q - 1'b1);
  assign drained     = !rd_inflight && (cnt == 2'd0);
  assign ifm_nonzero = (rl_q != '0) && (nr_q != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FILT;
      S_FILT:  if ((fs_q == '0) || (mem_ren && f_last))
                 state_nxt = ifm_nonzero ? S_IFMAP : S_DRAIN;
      S_IFMAP: if (mem_ren && i_last) state_nxt = S_DRAIN;
      S_DRAIN: if (drained) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ren  = 1'b0;
    mem_addr = '0;
    rd_tag   = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_FILT: begin
        busy = 1'b1;
        if ((fs_q != '0) && can_issue) begin
          mem_ren  = 1'b1;
          mem_addr = f_addr;
        end
      end
      S_IFMAP: begin
        busy = 1'b1;
        if (can_issue) begin
          mem_ren  = 1'b1;
          mem_addr = i_addr;
          rd_tag   = '{tgt_ifm: 1'b1, sr: (col == '0), er: (col == rl_q - 1'b1)};
        end
      end
      S_DRAIN: begin
        done = drained;
        busy = !drained;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_addr      <= '0;
      i_addr      <= '0;
      fs_q        <= '0;
      rl_q        <= '0;
      nr_q        <= '0;
      f_cnt       <= '0;
      col         <= '0;
      row         <= '0;
      rd_inflight <= 1'b0;
      rd_tag_q    <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      cnt         <= 2'd0;
      for (int i = 0; i < 2; i++) skid_mem[i] <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        f_addr <= filter_base;
        i_addr <= ifmap_base;
        fs_q   <= filter_size;
        rl_q   <= row_len;
        nr_q   <= num_rows;
        f_cnt  <= '0;
        col    <= '0;
        row    <= '0;
      end
      if (mem_ren) begin
        if (state == S_FILT) begin
          f_addr <= f_addr + 1'b1;
          f_cnt  <= f_cnt + 1'b1;
        end else begin
          i_addr <= i_addr + 1'b1;
          if (col == rl_q - 1'b1) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
      rd_inflight <= mem_ren;
      rd_tag_q    <= rd_tag;
      if (rd_inflight) begin
        skid_mem[wr_ptr] <= '{data: mem_rdata, tag: rd_tag_q};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, rd_inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_pe_input_feeder.sv
// Randomized bench for pe_input_feeder: a memory model answers reads, and the
// observed buffer writes are compared against lists built from the config.
module tb_pe_input_feeder;
  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [11:0] ifmap_base = 0, filter_base = 0;
  logic [7:0]  row_len = 0, num_rows = 0, filter_size = 0;
  logic        mem_ren;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata = 0;
  logic [17:0] IFMap_in;
  logic        wen_IFMap_buffer;
  logic        IFMap_full = 0;
  logic [7:0]  Filter_in;
  logic        wen_Filter_buffer;
  logic        Filter_full = 0;
  logic        busy, done;

  pe_input_feeder dut (
    .clk(clk), .rst(rst), .start(start),
    .ifmap_base(ifmap_base), .filter_base(filter_base),
    .row_len(row_len), .num_rows(num_rows), .filter_size(filter_size),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .IFMap_in(IFMap_in), .wen_IFMap_buffer(wen_IFMap_buffer), .IFMap_full(IFMap_full),
    .Filter_in(Filter_in), .wen_Filter_buffer(wen_Filter_buffer), .Filter_full(Filter_full),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, c0 = 0;
  bit mon_on = 0, bp_on = 0;
  int hold_at = 0, hold_ifm = 0, full_run = 0, hold_cycles = 0, hold_ren = 0;

  logic [11:0] ren_q[$];
  int          ren_t[$], fw_t[$], iw_t[$], done_t[$];
  logic [7:0]  fw_q[$];
  logic [17:0] iw_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mval(input logic [11:0] a);
    logic [31:0] t;
    t = ({20'd0, a} * 32'd40503) ^ 32'h5A5A;
    return t[15:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory: data appears the cycle after the strobe.
  logic        p_ren;
  logic [11:0] p_addr;
  always @(negedge clk) begin
    p_ren  = mem_ren;
    p_addr = mem_addr;
  end
  always @(posedge clk) mem_rdata <= p_ren ? mval(p_addr) : 16'($urandom);

  always @(posedge clk) begin
    #1;
    if (hold_at > 0 && iw_q.size() >= hold_at) begin
      hold_ifm = 5;
      hold_at  = 0;
    end
    if (hold_ifm > 0) begin
      IFMap_full = 1;
      hold_ifm--;
    end else begin
      IFMap_full = bp_on ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    Filter_full = bp_on ? ($urandom_range(0, 2) == 0) : 1'b0;
  end

  always @(negedge clk) begin
    int rel;
    rel = cyc - c0;
    if (mon_on) begin
      if (mem_ren) begin ren_q.push_back(mem_addr); ren_t.push_back(rel); end
      else check("addr_idle", {20'd0, mem_addr}, 0);
      if (wen_Filter_buffer) begin fw_q.push_back(Filter_in); fw_t.push_back(rel); end
      else check("flt_idle", {24'd0, Filter_in}, 0);
      if (wen_IFMap_buffer) begin iw_q.push_back(IFMap_in); iw_t.push_back(rel); end
      else check("ifm_idle", {14'd0, IFMap_in}, 0);
      if (done) begin done_t.push_back(rel); check("busy_at_done", {31'd0, busy}, 0); end
      if (rel == 1) check("busy_after_start", {31'd0, busy}, 1);
      check("ifm_wen_full", {31'd0, wen_IFMap_buffer & IFMap_full}, 0);
      check("flt_wen_full", {31'd0, wen_Filter_buffer & Filter_full}, 0);
      full_run = IFMap_full ? full_run + 1 : 0;
      if (IFMap_full && !bp_on) hold_cycles++;
      if (IFMap_full && !bp_on && full_run >= 2 && mem_ren) hold_ren++;
    end
  end

  task automatic clear_logs();
    ren_q.delete(); ren_t.delete(); fw_q.delete(); fw_t.delete();
    iw_q.delete(); iw_t.delete(); done_t.delete();
  endtask

  task automatic kick(input logic [11:0] fb, input int fs, input logic [11:0] ib,
                      input int rl, input int nr);
    @(posedge clk); #1;
    filter_base = fb; filter_size = 8'(fs);
    ifmap_base  = ib; row_len = 8'(rl); num_rows = 8'(nr);
    start = 1;
    c0 = cyc;
    clear_logs();
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic run_xfer(input logic [11:0] fb, input int fs, input logic [11:0] ib,
                          input int rl, input int nr, input bit bp, input bit tchk,
                          input bit poke, input int hold);
    logic [11:0] exp_ra[$];
    logic [7:0]  exp_fw[$];
    logic [17:0] exp_iw[$];
    logic [11:0] a;
    int s, total, n;
    // Reference: filter words in address order, then rows of IFMap words.
    for (int i = 0; i < fs; i++) begin
      s = fb + i; a = s[11:0];
      exp_ra.push_back(a);
      exp_fw.push_back(mval(a) & 16'hFF);
    end
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < rl; c++) begin
        s = ib + r * rl + c; a = s[11:0];
        exp_ra.push_back(a);
        exp_iw.push_back({c == 0, c == rl - 1, mval(a)});
      end
    total = exp_ra.size();
    bp_on = bp;
    kick(fb, fs, ib, rl, nr);
    hold_at = hold; hold_cycles = 0; hold_ren = 0;
    if (poke) begin
      start = 1;
      filter_base = 12'($urandom); filter_size = 8'($urandom_range(1, 9));
      ifmap_base = 12'($urandom); row_len = 8'($urandom_range(1, 9));
      @(posedge clk); #1;
      start = 0;
    end
    for (int k = 0; k < 3000 && done_t.size() == 0; k++) @(negedge clk);
    if (done_t.size() == 0) check("done_timeout", 0, 1);
    repeat (4) @(negedge clk);
    bp_on = 0;
    check("done_cnt", done_t.size(), 1);
    check("n_ren", ren_q.size(), total);
    check("n_fw", fw_q.size(), exp_fw.size());
    check("n_iw", iw_q.size(), exp_iw.size());
    n = (ren_q.size() < total) ? ren_q.size() : total;
    for (int i = 0; i < n; i++) check($sformatf("addr[%0d]", i), {20'd0, ren_q[i]}, {20'd0, exp_ra[i]});
    n = (fw_q.size() < exp_fw.size()) ? fw_q.size() : exp_fw.size();
    for (int i = 0; i < n; i++) check($sformatf("fw[%0d]", i), {24'd0, fw_q[i]}, {24'd0, exp_fw[i]});
    n = (iw_q.size() < exp_iw.size()) ? iw_q.size() : exp_iw.size();
    for (int i = 0; i < n; i++) check($sformatf("iw[%0d]", i), {14'd0, iw_q[i]}, {14'd0, exp_iw[i]});
    if (fw_t.size() > 0 && iw_t.size() > 0)
      check("flt_before_ifm", {31'd0, fw_t[fw_t.size()-1] < iw_t[0]}, 1);
    if (tchk && done_t.size() > 0) begin
      if (total == 0) check("done_t_zero", done_t[0], 2);
      else begin
        check("done_t", done_t[0], 3 + total);
        if (ren_t.size() > 0) check("first_ren_t", ren_t[0], 1);
        for (int i = 0; i < fw_t.size(); i++) check($sformatf("fw_t[%0d]", i), fw_t[i], 3 + i);
        for (int i = 0; i < iw_t.size(); i++)
          check($sformatf("iw_t[%0d]", i), iw_t[i], 3 + fw_t.size() + i);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_ren", {31'd0, mem_ren}, 0);
    check("rst_wen", {30'd0, wen_IFMap_buffer, wen_Filter_buffer}, 0);
    check("rst_busy_done", {30'd0, busy, done}, 0);
    check("rst_data", {6'd0, IFMap_in, Filter_in}, 0);
    mon_on = 1;

    run_xfer(12'h100, 3, 12'h200, 4, 2, 0, 1, 0, 0);
    run_xfer(12'h100, 3, 12'h200, 4, 2, 0, 0, 0, 2);
    check("hold_cycles", hold_cycles, 5);
    check("hold_ren", hold_ren, 0);
    run_xfer(12'h040, 0, 12'h300, 1, 3, 0, 0, 0, 0);
    run_xfer(12'h000, 0, 12'h000, 0, 0, 0, 1, 0, 0);
    run_xfer(12'hFFE, 4, 12'hFFD, 3, 2, 0, 1, 1, 0);

    // Reset in the middle of the IFMap phase.
    kick(12'h100, 3, 12'h200, 4, 3);
    for (int k = 0; k < 200 && iw_q.size() < 3; k++) @(negedge clk);
    check("pre_rst_progress", {31'd0, iw_q.size() >= 3}, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("mid_rst_out", {mem_ren, wen_IFMap_buffer, wen_Filter_buffer, busy, done}, 0);
    check("mid_rst_data", {6'd0, IFMap_in, Filter_in}, 0);
    clear_logs();
    repeat (10) @(negedge clk);
    check("post_rst_quiet", ren_q.size() + fw_q.size() + iw_q.size() + done_t.size(), 0);
    run_xfer(12'h100, 3, 12'h200, 4, 2, 0, 1, 0, 0);

    for (int it = 0; it < 8; it++)
      run_xfer(12'($urandom), $urandom_range(0, 5), 12'($urandom), $urandom_range(0, 4),
               $urandom_range(0, 3), it[0], 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
